ram_arbiter: RTL and testbench

//  Sequences and shares the single data read/write port pair of the block RAM between two requesters:

---
 rtl/ram_arbiter_pkg.sv | 54 +++++
 rtl/ram_arbiter_if.sv | 44 ++++
 rtl/ram_arbiter_mem_lane_fmt.sv | 24 ++
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arb_pkg: shared types and lane helpers for the two-requester RAM data-port arbiter.
//   state_t    : arbiter FSM states
//   mem_size_t : request access size encoding (byte / half / word / illegal)
//   byte_en, store_align, load_extract : lane helpers used by mem_lane_fmt
package ram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } mem_size_t;

  function automatic logic [3:0] byte_en(mem_size_t size, logic [1:0] off);
    case (size)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = 4'b0011 << off;
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Store data is right-aligned by the requester; replicating it across the
  // lanes lets the byte enables alone pick the target lane.
  function automatic logic [31:0] store_align(mem_size_t size, logic [31:0] data);
    case (size)
      SZ_B:    store_align = {4{data[7:0]}};
      SZ_H:    store_align = {2{data[15:0]}};
      SZ_W:    store_align = data;
      default: store_align = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(mem_size_t size, logic [1:0] off,
                                               logic uns, logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    load_extract = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_H:    load_extract = {{16{~uns & sh[15]}}, sh[15:0]};
      SZ_W:    load_extract = sh;
      default: load_extract = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/response bundle for both requesters plus the RAM data port.
//   req_*      : per-requester request handshake and payload
//   rsp_*      : response pulse, error flag and formatted load data
//   mem_*      : RAM data-port controls, write data and registered read data
// Modports: slave = the arbiter, master = requesters and RAM together.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 10
);
  import ram_arb_pkg::*;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_we;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][1:0]            req_size;
  logic [NUM_REQ-1:0]                 req_unsigned;
  logic [NUM_REQ-1:0][31:0]           req_wdata;

  logic [NUM_REQ-1:0]                 rsp_valid;
  logic                               rsp_err;
  logic [31:0]                        rsp_rdata;

  logic                               mem_clk_en;
  logic                               mem_read_req;
  logic [MEM_AW-1:0]                  mem_addr;
  logic                               mem_we;
  logic [3:0]                         mem_be;
  logic [31:0]                        mem_wdata;
  logic [31:0]                        mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_clk_en, mem_read_req, mem_addr, mem_we, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_clk_en, mem_read_req, mem_addr, mem_we, mem_be, mem_wdata
  );

endinterface

// File: rtl/ram_arbiter_mem_lane_fmt.sv
// mem_lane_fmt: combinational lane formatter between a sized request and the 32-bit RAM port.
//   size, off, uns : latched request size, byte offset and zero-extend flag
//   wdata          : right-aligned store data
//   rword          : raw RAM read word
//   be, wdata_lane : byte enables and lane-replicated store data
//   rdata          : shifted, truncated and extended load data
module mem_lane_fmt
  import ram_arb_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata
);

  assign be         = byte_en(size, off);
  assign wdata_lane = store_align(size, wdata);
  assign rdata      = load_extract(size, off, uns, rword);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the block-RAM data port between the load/store unit (0) and the
// debug/program loader (1), one outstanding request at a time, round-robin on contention.
//   clk, rst : clock, asynchronous active-high reset
//   clk_en   : global enable; FSM, request latch and round-robin pointer advance only when high
//   bus      : ram_arbiter_if.slave (requests, responses, RAM data port)
//
// state | meaning
// IDLE  | waiting for a request; grants and latches one
// ISSUE | drives the RAM read or write for the latched request
// RESP  | one-cycle response to the granted requester
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int MEM_AW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  ram_arbiter_if.slave  bus
);

  state_t                 state, state_nxt;
  logic                   last_g;
  logic                   g_q;
  logic                   we_q;
  logic                   uns_q;
  logic                   err_q;
  mem_size_t              size_q;
  logic [MEM_AW+1:0]      addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;

  logic                   any_valid;
  logic                   g_sel;
  logic                   accept;
  logic                   req_err;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  mem_size_t              sel_size;

  logic [3:0]             fmt_be;
  logic [DATA_WIDTH-1:0]  fmt_wdata;
  logic [DATA_WIDTH-1:0]  fmt_rdata;

  // On contention the requester not served last wins; otherwise the lone
  // valid one is taken.
  always_comb begin
    any_valid = |bus.req_valid;
    if (&bus.req_valid) g_sel = ~last_g;
    else                g_sel = bus.req_valid[1];
    sel_addr = bus.req_addr[g_sel];
    sel_size = mem_size_t'(bus.req_size[g_sel]);
  end

  always_comb begin
    case (sel_size)
      SZ_BAD:  req_err = 1'b1;
      SZ_H:    req_err = sel_addr[0];
      SZ_W:    req_err = |sel_addr[1:0];
      default: req_err = 1'b0;
    endcase
    if ({2'b00, sel_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_WORDS)) req_err = 1'b1;
  end

  // Ready is qualified by clk_en so that a visible handshake always means the
  // request was actually latched.
  assign accept = (state == IDLE) && any_valid && clk_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_g  <= 1'b1;
      g_q     <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (clk_en) begin
      state <= state_nxt;
      if (accept) begin
        last_g  <= g_sel;
        g_q     <= g_sel;
        we_q    <= bus.req_we[g_sel];
        uns_q   <= bus.req_unsigned[g_sel];
        err_q   <= req_err;
        size_q  <= sel_size;
        addr_q  <= sel_addr[MEM_AW+1:0];
        wdata_q <= bus.req_wdata[g_sel];
      end
    end
  end

  mem_lane_fmt u_fmt (
    .size       (size_q),
    .off        (addr_q[1:0]),
    .uns        (uns_q),
    .wdata      (wdata_q),
    .rword      (bus.mem_rdata),
    .be         (fmt_be),
    .wdata_lane (fmt_wdata),
    .rdata      (fmt_rdata)
  );

  assign bus.mem_clk_en = clk_en;

  // RAM controls decode the state directly, so an async reset in ISSUE
  // removes the write strobe before the next edge.
  always_comb begin
    state_nxt        = state;
    bus.req_ready    = '0;
    bus.rsp_valid    = '0;
    bus.rsp_err      = 1'b0;
    bus.rsp_rdata    = '0;
    bus.mem_read_req = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_be       = '0;
    bus.mem_wdata    = '0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          bus.req_ready[g_sel] = clk_en;
          state_nxt = req_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_addr = addr_q[MEM_AW+1:2];
        if (we_q) begin
          bus.mem_we    = 1'b1;
          bus.mem_be    = fmt_be;
          bus.mem_wdata = fmt_wdata;
        end else begin
          bus.mem_read_req = 1'b1;
        end
        state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid[g_q] = 1'b1;
        bus.rsp_err        = err_q;
        if (!err_q && !we_q) bus.rsp_rdata = fmt_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int MEM_WORDS = 1024;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_WIDTH(32), .MEM_AW(10)) bus ();

  ram_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS), .MEM_AW(10)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  // RAM with registered read port, gated by the RAM clock enable
  logic [31:0] ram [MEM_WORDS];
  always @(posedge clk) begin
    if (bus.mem_clk_en) begin
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      if (bus.mem_read_req) bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // byte-addressed reference memory
  logic [7:0] ref_mem [4*MEM_WORDS];

  int n_cmp = 0;
  int n_bad = 0;
  int both_ready = 0;
  int both_rsp = 0;

  always @(negedge clk) begin
    if (!rst && (&bus.req_ready)) both_ready++;
    if (!rst && (&bus.rsp_valid)) both_rsp++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(logic [1:0] size, logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || ((addr / 4) >= MEM_WORDS);
  endfunction

  function automatic logic [31:0] exp_load(logic [1:0] size, logic [31:0] addr, logic uns);
    logic [31:0] v;
    int n;
    n = 1 << size;
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(addr) + k]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic do_req(input int idx, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input int stall);
    logic        err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    int          lat;
    int          wait_c;
    logic        saw_we, saw_rd, rsp_seen, got_err;
    logic [3:0]  got_be;
    logic [9:0]  got_addr;
    logic [31:0] got_rd;
    err    = exp_err(size, addr);
    exp_rd = (err || we) ? 32'h0 : exp_load(size, addr, uns);
    exp_be = 4'h0;
    if (!err && we) for (int k = 0; k < (1 << size); k++) exp_be[int'(addr[1:0]) + k] = 1'b1;

    @(negedge clk);
    bus.req_valid[idx]    = 1'b1;
    bus.req_we[idx]       = we;
    bus.req_addr[idx]     = addr;
    bus.req_size[idx]     = size;
    bus.req_unsigned[idx] = uns;
    bus.req_wdata[idx]    = wdata;
    #1;
    wait_c = 0;
    while (!bus.req_ready[idx] && wait_c < 20) begin
      @(negedge clk); #1;
      wait_c++;
    end
    chk("accept_in_time", 32'(wait_c < 20), 32'h1);
    @(negedge clk);
    bus.req_valid[idx] = 1'b0;
    lat = 1; saw_we = 0; saw_rd = 0; rsp_seen = 0; got_err = 0;
    got_be = 0; got_addr = 0; got_rd = 0;
    if (stall > 0) begin
      clk_en = 1'b0;
      #1 chk("mem_clk_en_low", 32'(bus.mem_clk_en), 32'h0);
      repeat (stall) @(negedge clk);
      clk_en = 1'b1;
      lat += stall;
    end
    while (!rsp_seen && lat < 12) begin
      if (bus.mem_we)       begin saw_we = 1; got_be = bus.mem_be; got_addr = bus.mem_addr; end
      if (bus.mem_read_req) begin saw_rd = 1; got_addr = bus.mem_addr; end
      if (bus.rsp_valid[idx]) begin
        rsp_seen = 1; got_err = bus.rsp_err; got_rd = bus.rsp_rdata;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("rsp_seen", 32'(rsp_seen), 32'h1);
    chk("latency", 32'(lat), 32'((err ? 1 : 2) + stall));
    chk("rsp_err", 32'(got_err), 32'(err));
    chk("rsp_rdata", got_rd, exp_rd);
    chk("mem_we_seen", 32'(saw_we), 32'(!err && we));
    chk("mem_rd_seen", 32'(saw_rd), 32'(!err && !we));
    if (!err) chk("mem_addr", 32'(got_addr), 32'(addr[11:2]));
    if (!err && we) chk("mem_be", 32'(got_be), 32'(exp_be));
    if (!err && we)
      for (int k = 0; k < (1 << size); k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
    @(negedge clk);
    chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'h0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int cyc;
    int rsp_any;
    logic [1:0] sz;
    logic [31:0] ad;
    for (int i = 0; i < MEM_WORDS; i++) ram[i] = 32'h0;
    for (int i = 0; i < 4 * MEM_WORDS; i++) ref_mem[i] = 8'h0;
    rst = 1'b1; clk_en = 1'b1;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0;
    bus.req_size = '0; bus.req_unsigned = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_rd", 32'(bus.mem_read_req), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);

    // contention from reset: strict alternation starting with requester 0
    bus.req_we = 2'b00; bus.req_size[0] = 2'b10; bus.req_size[1] = 2'b10;
    bus.req_addr[0] = 32'h0; bus.req_addr[1] = 32'h10;
    bus.req_valid = 2'b11;
    cyc = 0;
    while (grants.size() < 6 && cyc < 60) begin
      #1;
      if (bus.req_ready[0]) grants.push_back(0);
      else if (bus.req_ready[1]) grants.push_back(1);
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = 2'b00;
    chk("grant_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < grants.size(); i++) chk("grant_order", 32'(grants[i]), 32'(i % 2));
    repeat (4) @(negedge clk);

    // directed cases
    do_req(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0);
    do_req(0, 0, 32'h10, 2'b10, 0, 32'h0, 0);
    do_req(1, 1, 32'h13, 2'b00, 0, 32'h000000A5, 0);
    do_req(1, 0, 32'h13, 2'b00, 0, 32'h0, 0);
    do_req(1, 0, 32'h13, 2'b00, 1, 32'h0, 0);
    do_req(0, 1, 32'h4, 2'b10, 0, 32'h12345678, 0);
    do_req(0, 0, 32'h6, 2'b01, 0, 32'h0, 0);
    do_req(1, 0, 32'h5, 2'b01, 0, 32'h0, 0);
    do_req(0, 1, 32'h1000, 2'b10, 0, 32'h55AA55AA, 0);
    do_req(1, 1, 32'h8, 2'b11, 0, 32'h12345678, 0);
    do_req(0, 1, 32'hFFFF_FFF0, 2'b10, 0, 32'h1, 0);
    do_req(0, 0, 32'hFFC, 2'b10, 0, 32'h0, 0);

    // reset while a store is in ISSUE
    do_req(0, 1, 32'h20, 2'b10, 0, 32'h11223344, 0);
    @(negedge clk);
    bus.req_valid[0] = 1'b1; bus.req_we[0] = 1'b1; bus.req_addr[0] = 32'h20;
    bus.req_size[0] = 2'b10; bus.req_wdata[0] = 32'hCAFEF00D;
    #1 chk("rst_case_ready", 32'(bus.req_ready[0]), 32'h1);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    chk("rst_case_issue_we", 32'(bus.mem_we), 32'h1);
    rst = 1'b1;
    #1 chk("rst_case_we_drop", 32'(bus.mem_we), 32'h0);
    rsp_any = 0;
    repeat (2) begin @(negedge clk); rsp_any |= int'(|bus.rsp_valid); end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); rsp_any |= int'(|bus.rsp_valid); end
    chk("rst_case_no_rsp", 32'(rsp_any), 32'h0);
    do_req(1, 0, 32'h20, 2'b10, 0, 32'h0, 0);

    // clock-enable stall in the middle of a load
    do_req(1, 1, 32'h40, 2'b10, 0, 32'h89ABCDEF, 0);
    do_req(0, 0, 32'h40, 2'b10, 0, 32'h0, 3);
    do_req(1, 0, 32'h42, 2'b01, 0, 32'h0, 2);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ad = ($urandom_range(0, 11) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                        : 32'($urandom_range(0, 63));
      do_req($urandom_range(0, 1), 1'($urandom_range(0, 1)), ad, sz,
             1'($urandom_range(0, 1)), $urandom,
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    chk("ready_both", 32'(both_ready), 32'h0);
    chk("rsp_both", 32'(both_rsp), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
